// File: rtl/mcp3008_pkg.sv
// Shared types and constants for the MCP3008 SPI ADC responder model.
package mcp3008_pkg;

    localparam int CMD_BITS   = 4;
    localparam int DATA_BITS  = 10;
    localparam int NUM_CH     = 8;
    localparam int TRAIL_BITS = 9;

    typedef logic [DATA_BITS-1:0] adc_code_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        CMD,
        SAMPLE,
        NULL,
        DATA,
        TRAIL
    } state_e;

    // Differential mode pairs channel sel with sel^1; negative results clip to 0.
    function automatic adc_code_t compute_code(input logic [NUM_CH*DATA_BITS-1:0] ch,
                                               input logic sgl,
                                               input logic [2:0] sel);
        adc_code_t p;
        adc_code_t m;
        adc_code_t res;
        logic [DATA_BITS:0] diff;
        p = '0;
        m = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == 3'(i))
                p = ch[i*DATA_BITS +: DATA_BITS];
            if ((sel ^ 3'b001) == 3'(i))
                m = ch[i*DATA_BITS +: DATA_BITS];
        end
        diff = {1'b0, p} - {1'b0, m};
        if (sgl)
            res = p;
        else if (p <= m)
            res = '0;
        else if (diff[DATA_BITS])
            res = '1;
        else
            res = diff[DATA_BITS-1:0];
        return res;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer plus edge detector for one asynchronous SPI pin.
module spi_pin_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= (sync_q << 1) | STAGES'(pin);
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/mcp3008_responder.sv
// MCP3008 slave model: decodes the SPI command and returns the selected channel code.
// Define MCP3008_LSB_TRAIL_EN to repeat B1..B9 LSB-first after the MSB-first word.
module mcp3008_responder
    import mcp3008_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          AD_CLK,
    input  logic                          CS,
    input  logic                          DIN,
    output logic                          DOUT,
    output logic                          dout_oe,
    input  logic [NUM_CH*DATA_BITS-1:0]   ch_value,
    output logic                          conv_valid,
    output logic [2:0]                    conv_ch,
    output logic                          conv_sgl,
    output adc_code_t                     conv_code,
    output logic                          frame_abort,
    output state_e                        dbg_state
);

    logic ck_level, ck_rise, ck_fall;
    logic cs_level, cs_rise, cs_fall;
    logic din_level, din_rise, din_fall;
    logic sync_unused;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_ck (
        .clk(clk), .rst(rst), .pin(AD_CLK), .level(ck_level), .rise(ck_rise), .fall(ck_fall));
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .pin(CS), .level(cs_level), .rise(cs_rise), .fall(cs_fall));
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_din (
        .clk(clk), .rst(rst), .pin(DIN), .level(din_level), .rise(din_rise), .fall(din_fall));

    assign sync_unused = ^{ck_level, cs_fall, din_rise, din_fall};

    state_e    state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [CMD_BITS-1:0] cmd_q, cmd_d;
    adc_code_t shreg_q, shreg_d;
    adc_code_t code_now;
    logic      dout_q, dout_d, oe_q, oe_d;
    logic      valid_q, valid_d, abort_q, abort_d;
    logic [2:0] ch_q, ch_d;
    logic      sgl_q, sgl_d;
    adc_code_t conv_code_q, conv_code_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            shreg_q     <= '0;
            dout_q      <= 1'b0;
            oe_q        <= 1'b0;
            valid_q     <= 1'b0;
            abort_q     <= 1'b0;
            ch_q        <= '0;
            sgl_q       <= 1'b0;
            conv_code_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            shreg_q     <= shreg_d;
            dout_q      <= dout_d;
            oe_q        <= oe_d;
            valid_q     <= valid_d;
            abort_q     <= abort_d;
            ch_q        <= ch_d;
            sgl_q       <= sgl_d;
            conv_code_q <= conv_code_d;
        end
    end

    assign code_now = compute_code(ch_value, cmd_q[3], cmd_q[2:0]);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        shreg_d     = shreg_q;
        dout_d      = dout_q;
        oe_d        = oe_q;
        valid_d     = 1'b0;
        abort_d     = 1'b0;
        ch_d        = ch_q;
        sgl_d       = sgl_q;
        conv_code_d = conv_code_q;
        // CS release wins over any AD_CLK edge seen in the same cycle.
        if (cs_rise && state_q != IDLE) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            dout_d  = 1'b0;
            abort_d = (state_q == CMD) || (state_q == SAMPLE) ||
                      (state_q == NULL) || (state_q == DATA);
        end else begin
            case (state_q)
                IDLE: begin
                    if (!cs_level)
                        state_d = WAIT_START;
                end
                WAIT_START: begin
                    if (ck_rise && din_level) begin
                        state_d = CMD;
                        cnt_d   = '0;
                    end
                end
                CMD: begin
                    if (ck_rise) begin
                        cmd_d = {cmd_q[CMD_BITS-2:0], din_level};
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'(CMD_BITS - 1))
                            state_d = SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (ck_fall) begin
                        shreg_d     = code_now;
                        conv_code_d = code_now;
                        ch_d        = cmd_q[2:0];
                        sgl_d       = cmd_q[3];
                        valid_d     = 1'b1;
                        state_d     = NULL;
                    end
                end
                NULL: begin
                    if (ck_fall) begin
                        dout_d  = 1'b0;
                        oe_d    = 1'b1;
                        cnt_d   = '0;
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (ck_fall) begin
                        dout_d  = shreg_q[DATA_BITS-1];
                        shreg_d = {shreg_q[DATA_BITS-2:0], 1'b0};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'(DATA_BITS - 1)) begin
                            shreg_d = conv_code_q >> 1;
                            cnt_d   = '0;
                            state_d = TRAIL;
                        end
                    end
                end
                TRAIL: begin
                    if (ck_fall) begin
                        dout_d = 1'b0;
                        if (cnt_q < 4'(TRAIL_BITS)) begin
                            cnt_d = cnt_q + 4'd1;
`ifdef MCP3008_LSB_TRAIL_EN
                            dout_d  = shreg_q[0];
                            shreg_d = shreg_q >> 1;
`endif
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // conv_valid is a single-cycle strobe with no back-pressure; conv_ch/conv_sgl/conv_code
    // become valid with the strobe and hold until the next one.
    assign conv_valid  = valid_q;
    assign conv_ch     = ch_q;
    assign conv_sgl    = sgl_q;
    assign conv_code   = conv_code_q;
    assign frame_abort = abort_q;
    assign DOUT        = dout_q;
    assign dout_oe     = oe_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mcp3008_responder.sv
// Self-checking bench for mcp3008_responder: an SPI master drives random frames, a
// reference model predicts latched results and DOUT bits.
module tb_mcp3008_responder;
    import mcp3008_pkg::*;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ad_clk = 1'b0;
    logic        cs = 1'b1;
    logic        din = 1'b0;
    logic        dout;
    logic        dout_oe;
    logic [79:0] ch_value = '0;
    logic        conv_valid;
    logic [2:0]  conv_ch;
    logic        conv_sgl;
    adc_code_t   conv_code;
    logic        frame_abort;
    state_e      dbg_state;

    int checks = 0;
    int errors = 0;
    int abort_seen = 0;
    int abort_exp = 0;
    int hp = 4;
    logic [13:0] exp_q[$];
    logic [13:0] mon_e;

    mcp3008_responder #(.SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .AD_CLK(ad_clk), .CS(cs), .DIN(din),
        .DOUT(dout), .dout_oe(dout_oe), .ch_value(ch_value),
        .conv_valid(conv_valid), .conv_ch(conv_ch), .conv_sgl(conv_sgl),
        .conv_code(conv_code), .frame_abort(frame_abort), .dbg_state(dbg_state));

    always #10 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: every conv_valid strobe is matched against the oldest expected result.
    always @(negedge clk) begin
        if (!rst && frame_abort)
            abort_seen++;
        if (!rst && conv_valid) begin
            if (exp_q.size() == 0) begin
                chk("conv_unexpected", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("conv_ch", int'(conv_ch), int'(mon_e[13:11]));
                chk("conv_sgl", int'(conv_sgl), int'(mon_e[10]));
                chk("conv_code", int'(conv_code), int'(mon_e[9:0]));
            end
        end
    end

    function automatic int ref_code(input logic [79:0] chv, input int sgl, input int d);
        int p;
        int m;
        p = int'((chv >> (10 * d)) & 80'd1023);
        m = int'((chv >> (10 * (d ^ 1))) & 80'd1023);
        if (sgl != 0)
            return p;
        return (p > m) ? p - m : 0;
    endfunction

    function automatic int ref_trail(input int code, input int k);
`ifdef MCP3008_LSB_TRAIL_EN
        return (k < TRAIL_BITS) ? ((code >> (k + 1)) & 1) : 0;
`else
        return (code & 0) + (k & 0);
`endif
    endfunction

    function automatic logic [79:0] rand_ch();
        logic [79:0] v;
        v = '0;
        for (int i = 0; i < 8; i++)
            v[i*10 +: 10] = 10'($urandom_range(0, 1023));
        return v;
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input int b);
        din = b[0];
        wait_clks(hp);
        ad_clk = 1'b1;
        wait_clks(hp);
        ad_clk = 1'b0;
    endtask

    task automatic read_fall(output int v, output int oe);
        wait_clks(hp);
        ad_clk = 1'b1;
        wait_clks(hp);
        ad_clk = 1'b0;
        wait_clks(SYNC + 2);
        v  = int'(dout);
        oe = int'(dout_oe);
        wait_clks(hp - (SYNC + 2));
    endtask

    // abort_bits >= 0: raise CS after that many command bits; rst_after >= 0: reset
    // before reading that DOUT bit.
    task automatic run_frame(input logic [79:0] chv, input int sgl, input int d, input int lead,
                             input int abort_bits, input int rst_after, input int n_trail);
        int code;
        int bits[$];
        int v;
        int oe;
        code = ref_code(chv, sgl, d);
        hp = $urandom_range(4, 7);
        ch_value = chv;
        if (abort_bits < 0)
            exp_q.push_back({3'(d), 1'(sgl), 10'(code)});
        bits.push_back(0);
        for (int i = 9; i >= 0; i--)
            bits.push_back((code >> i) & 1);
        for (int k = 0; k < n_trail; k++)
            bits.push_back(ref_trail(code, k));

        @(negedge clk);
        cs = 1'b0;
        wait_clks(hp);
        repeat (lead) send_bit(0);
        send_bit(1);
        for (int i = 0; i < 4; i++) begin
            if (i == abort_bits) begin
                cs = 1'b1;
                abort_exp++;
                wait_clks(SYNC + 4);
                chk("abort_count", abort_seen, abort_exp);
                chk("abort_oe", int'(dout_oe), 0);
                chk("abort_dout", int'(dout), 0);
                chk("abort_state", int'(dbg_state), int'(IDLE));
                return;
            end
            send_bit((i == 0) ? sgl : ((d >> (3 - i)) & 1));
        end
        // The sample is already latched; moving the inputs must not alter the frame.
        wait_clks(SYNC + 3);
        ch_value = rand_ch();

        for (int i = 0; i < bits.size(); i++) begin
            if (i == rst_after) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_dout", int'(dout), 0);
                chk("rst_oe", int'(dout_oe), 0);
                cs = 1'b1;
                wait_clks(SYNC + 4);
                chk("rst_no_abort", abort_seen, abort_exp);
                chk("rst_state", int'(dbg_state), int'(IDLE));
                return;
            end
            read_fall(v, oe);
            chk($sformatf("dout_bit%0d", i), v, bits[i]);
            chk($sformatf("dout_oe%0d", i), oe, 1);
        end
        cs = 1'b1;
        wait_clks(SYNC + 3);
        chk("end_oe", int'(dout_oe), 0);
        chk("end_dout", int'(dout), 0);
        chk("end_no_abort", abort_seen, abort_exp);
    endtask

    initial begin
        logic [79:0] chv;
        int ab;
        wait_clks(3);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_dout", int'(dout), 0);
        chk("reset_oe", int'(dout_oe), 0);
        chk("reset_valid", int'(conv_valid), 0);
        chk("reset_abort", int'(frame_abort), 0);
        chk("reset_ch", int'(conv_ch), 0);
        chk("reset_sgl", int'(conv_sgl), 0);
        chk("reset_code", int'(conv_code), 0);
        chk("reset_state", int'(dbg_state), int'(IDLE));

        chv = rand_ch();
        chv[39:30] = 10'h2A5;
        run_frame(chv, 1, 3, 0, -1, -1, 9);
        run_frame(chv, 1, 3, 7, -1, -1, 0);

        chv = rand_ch();
        chv[49:40] = 10'd600;
        chv[59:50] = 10'd200;
        run_frame(chv, 0, 4, 0, -1, -1, 2);
        run_frame(chv, 0, 5, 1, -1, -1, 2);

        run_frame(rand_ch(), 1, 2, 0, 3, -1, 0);
        run_frame(rand_ch(), 1, 2, 0, -1, -1, 0);

        chv = rand_ch();
        chv[9:0] = 10'h301;
        run_frame(chv, 1, 0, 0, -1, -1, 12);

        run_frame(rand_ch(), 0, 6, 2, -1, 5, 0);
        run_frame(rand_ch(), 0, 6, 0, -1, -1, 3);

        for (int n = 0; n < 20; n++) begin
            ab = $urandom_range(0, 11);
            run_frame(rand_ch(), $urandom_range(0, 1), $urandom_range(0, 7),
                      $urandom_range(0, 7), (ab < 4) ? ab : -1, -1, $urandom_range(0, 12));
        end

        wait_clks(10);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("abort_total", abort_seen, abort_exp);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
